// File: rtl/perkalian_matrix_ctrl.sv
// Sequencer for a 3x3 matrix multiply over an external 3-term dot-product datapath.
// Holds operand matrices A/B and result matrix C; streams one (row, col) operand set per cycle.
module perkalian_matrix_ctrl #(
  parameter int DW     = 16,
  parameter int DP_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [3:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] dp_row_a,
  output logic [DW-1:0] dp_row_b,
  output logic [DW-1:0] dp_row_c,
  output logic [DW-1:0] dp_col_a,
  output logic [DW-1:0] dp_col_b,
  output logic [DW-1:0] dp_col_c,
  input  logic [DW-1:0] dp_result,
  input  logic [3:0]    rd_addr,
  output logic [DW-1:0] rd_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  // Cycle counter spans ISSUE and DRAIN: 0..8 issue, 9..8+DP_LAT drain.
  localparam int CW = $clog2(DP_LAT + 10);
  localparam logic [CW-1:0] ISSUE_LAST = CW'(8);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(8 + DP_LAT);
  localparam logic [CW-1:0] CYC_ONE    = CW'(1);
  localparam logic [CW:0]   LAT_W      = (CW+1)'(DP_LAT);
  localparam logic [CW:0]   ONE_W      = (CW+1)'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [3:0]    cap_q, cap_d;
  logic          err_q, err_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic [DW-1:0] a_q [9];
  logic [DW-1:0] a_d [9];
  logic [DW-1:0] b_q [9];
  logic [DW-1:0] b_d [9];
  logic [DW-1:0] c_q [9];
  logic [DW-1:0] c_d [9];

  logic       busy_w;
  logic       host_ok;
  logic       capture_en;
  logic [3:0] issue_k;
  logic [3:0] row_base;
  logic [3:0] col;

  assign busy_w  = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign host_ok = (state_q == S_IDLE) || (state_q == S_DONE);
  // Element k returns DP_LAT cycles after issue, so capture starts once cyc_q reaches DP_LAT.
  assign capture_en = busy_w && (({1'b0, cyc_q} + ONE_W) > LAT_W);

  // NOTE: every signal written in a combinational block gets a default first,
  // otherwise paths that skip an assignment infer latches.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    cap_d     = cap_q;
    err_d     = 1'b0;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    rd_data_d = (rd_addr <= 4'd8) ? c_q[rd_addr] : '0;

    if (capture_en) begin
      c_d[cap_q] = dp_result;
      cap_d      = cap_q + 4'd1;
    end

    if (host_ok && wr_en) begin
      if (wr_addr <= 4'd8) begin
        if (wr_sel) b_d[wr_addr] = wr_data;
        else        a_d[wr_addr] = wr_data;
      end else begin
        err_d = 1'b1;
      end
    end

    if (busy_w && (wr_en || start)) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          cyc_d   = '0;
          cap_d   = '0;
        end
      end
      S_ISSUE: begin
        cyc_d = cyc_q + CYC_ONE;
        if (cyc_q == ISSUE_LAST) state_d = (DP_LAT > 0) ? S_DRAIN : S_DONE;
      end
      S_DRAIN: begin
        cyc_d = cyc_q + CYC_ONE;
        if (cyc_q == DRAIN_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand selection: issue index k maps to row i = k/3 and column j = k%3.
  always_comb begin
    issue_k  = cyc_q[3:0];
    row_base = 4'd0;
    col      = 4'd0;
    dp_row_a = '0;
    dp_row_b = '0;
    dp_row_c = '0;
    dp_col_a = '0;
    dp_col_b = '0;
    dp_col_c = '0;
    if (state_q == S_ISSUE) begin
      if (issue_k < 4'd3)      row_base = 4'd0;
      else if (issue_k < 4'd6) row_base = 4'd3;
      else                     row_base = 4'd6;
      col      = issue_k - row_base;
      dp_row_a = a_q[row_base];
      dp_row_b = a_q[row_base + 4'd1];
      dp_row_c = a_q[row_base + 4'd2];
      dp_col_a = b_q[col];
      dp_col_b = b_q[col + 4'd3];
      dp_col_c = b_q[col + 4'd6];
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      cap_q     <= '0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      // NOTE: the matrices must read back as zero after reset, so they are plain
      // flops with a reset rather than a RAM macro that cannot be cleared.
      for (int i = 0; i < 9; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      cap_q     <= cap_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
    end
  end

  assign busy    = busy_w;
  assign done    = (state_q == S_DONE);
  assign err     = err_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_perkalian_matrix_ctrl.sv
// Bench for perkalian_matrix_ctrl: three instances (DP_LAT 0, 1, 3) share stimulus and are
// checked against a plain matrix-multiply reference model and cycle-exact timing expectations.
module tb_perkalian_matrix_ctrl;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst, wr_en, wr_sel, start;
  logic [3:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;

  logic        busy_w [NI];
  logic        done_w [NI];
  logic        err_w  [NI];
  logic [15:0] rd_w   [NI];
  logic [15:0] ra [NI];
  logic [15:0] rb [NI];
  logic [15:0] rc [NI];
  logic [15:0] ca [NI];
  logic [15:0] cb [NI];
  logic [15:0] cc [NI];
  logic [15:0] dp_res [NI];

  int checks   = 0;
  int failures = 0;

  logic [15:0] ma [9];
  logic [15:0] mb [9];
  logic [15:0] mc [9];

  always #5 clk = ~clk;

  function automatic int lat_of(input int g);
    return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    logic [15:0] prod;
    assign prod = ra[g] * ca[g] + rb[g] * cb[g] + rc[g] * cc[g];
    if (LAT == 0) begin : g_comb
      assign dp_res[g] = prod;
    end else begin : g_pipe
      logic [15:0] pipe [LAT];
      always @(posedge clk) begin
        pipe[0] <= prod;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
      assign dp_res[g] = pipe[LAT-1];
    end

    perkalian_matrix_ctrl #(.DW(16), .DP_LAT(LAT)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_sel    (wr_sel),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .start     (start),
      .busy      (busy_w[g]),
      .done      (done_w[g]),
      .err       (err_w[g]),
      .dp_row_a  (ra[g]),
      .dp_row_b  (rb[g]),
      .dp_row_c  (rc[g]),
      .dp_col_a  (ca[g]),
      .dp_col_b  (cb[g]),
      .dp_col_c  (cc[g]),
      .dp_result (dp_res[g]),
      .rd_addr   (rd_addr),
      .rd_data   (rd_w[g])
    );
  end

  task automatic check(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, g, obs, exp);
    end
  endtask

  // Reference: C = A x B, truncated to 16 bits.
  function automatic void recompute();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        int unsigned s = 0;
        for (int k = 0; k < 3; k++) s += ma[3*i+k] * mb[3*k+j];
        mc[3*i+j] = s[15:0];
      end
  endfunction

  task automatic write(input logic sel, input logic [3:0] addr, input logic [15:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    for (int g = 0; g < NI; g++) check("wr_err", g, err_w[g], (addr > 4'd8) ? 1 : 0);
    if (addr <= 4'd8) begin
      if (sel) mb[addr] = data;
      else     ma[addr] = data;
    end
  endtask

  task automatic load(input logic [15:0] a [9], input logic [15:0] b [9]);
    for (int i = 0; i < 9; i++) write(1'b0, 4'(i), a[i]);
    for (int i = 0; i < 9; i++) write(1'b1, 4'(i), b[i]);
  endtask

  task automatic check_c();
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check("dp_idle_row", g, {ra[g], rb[g]}, 32'h0);
      check("dp_idle_col", g, {ca[g], cc[g]}, 32'h0);
    end
    for (int a = 0; a < 11; a++) begin
      @(negedge clk);
      rd_addr = 4'(a + 5);
      rd_addr = (a < 10) ? 4'(a) : 4'd15;
      @(negedge clk);
      for (int g = 0; g < NI; g++)
        check("rd_c", g, rd_w[g], (a < 9) ? mc[a] : 16'h0);
    end
  endtask

  // inject > 0: illegal write A[0]=5 plus start driven in cycle s+inject.
  // ws: write A[8]=ws_data in the same cycle as start.
  task automatic run(input int inject, input bit ws, input logic [15:0] ws_data);
    @(negedge clk);
    start = 1'b1;
    if (ws) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd8; wr_data = ws_data;
      ma[8] = ws_data;
    end
    recompute();
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      for (int g = 0; g < NI; g++) begin
        check("busy", g, busy_w[g], (n <= 9 + lat_of(g)) ? 1 : 0);
        check("done", g, done_w[g], (n == 10 + lat_of(g)) ? 1 : 0);
        check("err_run", g, err_w[g], (inject != 0 && n == inject + 1) ? 1 : 0);
      end
      if (n == inject) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 16'd5; start = 1'b1;
      end
    end
    check_c();
  endtask

  task automatic rand_load();
    logic [15:0] a [9];
    logic [15:0] b [9];
    for (int i = 0; i < 9; i++) begin
      a[i] = 16'($urandom);
      b[i] = 16'($urandom);
    end
    load(a, b);
  endtask

  initial begin
    logic [15:0] a [9];
    logic [15:0] b [9];

    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; start = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    for (int i = 0; i < 9; i++) begin ma[i] = '0; mb[i] = '0; mc[i] = '0; end
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check("rst_busy", g, busy_w[g], 0);
      check("rst_done", g, done_w[g], 0);
      check("rst_err", g, err_w[g], 0);
      check("rst_rd", g, rd_w[g], 0);
      check("rst_dp", g, {rc[g], cb[g]}, 0);
    end
    rst = 1'b0;
    check_c();

    // Identity x {1..9}
    for (int i = 0; i < 9; i++) begin
      a[i] = (i % 4 == 0) ? 16'd1 : 16'd0;
      b[i] = 16'(i + 1);
    end
    load(a, b);
    run(0, 1'b0, 16'h0);

    // All 2 x all 3
    for (int i = 0; i < 9; i++) begin a[i] = 16'd2; b[i] = 16'd3; end
    load(a, b);
    run(0, 1'b0, 16'h0);

    // {1..9} x {9..1}
    for (int i = 0; i < 9; i++) begin a[i] = 16'(i + 1); b[i] = 16'(9 - i); end
    load(a, b);
    run(0, 1'b0, 16'h0);

    // Truncation cases
    for (int i = 0; i < 9; i++) begin a[i] = 16'h0100; b[i] = 16'h0100; end
    load(a, b);
    run(0, 1'b0, 16'h0);
    for (int i = 0; i < 9; i++) begin a[i] = 16'h00FF; b[i] = 16'h00FF; end
    load(a, b);
    run(0, 1'b0, 16'h0);

    // Illegal requests while busy, then rerun to confirm A was not modified
    rand_load();
    run(3, 1'b0, 16'h0);
    run(0, 1'b0, 16'h0);

    // Out-of-range write address in IDLE
    write(1'b0, 4'd9, 16'hBEEF);
    write(1'b1, 4'd15, 16'hDEAD);
    run(0, 1'b0, 16'h0);

    // Write coinciding with start lands before element 0
    run(0, 1'b1, 16'($urandom));

    // Randomised operand sets
    for (int r = 0; r < 4; r++) begin
      rand_load();
      run(0, 1'b0, 16'h0);
    end

    // Reset at issue index 4
    rand_load();
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      start = 1'b0;
      for (int g = 0; g < NI; g++) check("pre_rst_busy", g, busy_w[g], 1);
      if (n == 5) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < NI; g++) begin
      check("post_rst_busy", g, busy_w[g], 0);
      check("post_rst_err", g, err_w[g], 0);
    end
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) check("post_rst_done", g, done_w[g], 0);
    end
    for (int i = 0; i < 9; i++) begin ma[i] = '0; mb[i] = '0; mc[i] = '0; end
    check_c();
    rand_load();
    run(0, 1'b0, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
